// File: rtl/ppu_sprite_eval_engine_if.sv
// Bus bundle for the per-scanline sprite evaluator: evaluation control,
// sprite RAM access and the secondary OAM read port.
//
// Handshake semantics: start is a one-cycle request that is accepted only
// while the engine is idle (busy low and no done pulse in flight); a start
// seen at any other time is dropped. busy rises the cycle after an accepted
// start and falls in the cycle that done pulses. spram_data_in must carry
// the byte at the spram_addr driven one cycle earlier. rd_slot is sampled
// every cycle and the rd_* outputs follow it with one cycle of latency.
interface ppu_sprite_eval_engine_if #(
    parameter int SLOT_W = 4
);
    logic              start;
    logic [8:0]        curr_row;
    logic              sprite_size;
    logic [7:0]        cpu_sprite_addr;
    logic [7:0]        spram_addr;
    logic [7:0]        spram_data_in;
    logic              busy;
    logic              done;
    logic              sprite_overflow;
    logic [4:0]        sprite_count;
    logic [SLOT_W-1:0] rd_slot;
    logic              rd_valid;
    logic [7:0]        rd_y;
    logic [7:0]        rd_tile;
    logic [7:0]        rd_attr;
    logic [7:0]        rd_x;
    logic              rd_is_0;
    logic [2:0]        dbg_state;

    // Engine side.
    modport slave (
        input  start, curr_row, sprite_size, cpu_sprite_addr, spram_data_in, rd_slot,
        output spram_addr, busy, done, sprite_overflow, sprite_count,
               rd_valid, rd_y, rd_tile, rd_attr, rd_x, rd_is_0, dbg_state
    );

    // Sequencer / renderer side.
    modport master (
        output start, curr_row, sprite_size, cpu_sprite_addr, spram_data_in, rd_slot,
        input  spram_addr, busy, done, sprite_overflow, sprite_count,
               rd_valid, rd_y, rd_tile, rd_attr, rd_x, rd_is_0, dbg_state
    );
endinterface

// File: rtl/ppu_sprite_eval_engine.sv
// Per-scanline sprite evaluator. Scans primary OAM for sprites covering
// curr_row and copies up to MAX_SPRITES of them into the back bank of a
// double-buffered secondary OAM; the front bank is what the renderer reads.
// The banks swap on the done pulse.
module ppu_sprite_eval_engine #(
    parameter int MAX_SPRITES = 8,
    parameter int NUM_OAM     = 64,
    parameter int SLOT_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    ppu_sprite_eval_engine_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CHECK = 3'd2,
        S_LD_T  = 3'd3,
        S_LD_A  = 3'd4,
        S_LD_X  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // k counts 0..NUM_OAM, so it needs one bit beyond the 6 that index 64 entries.
    localparam int             K_W     = 7;
    localparam logic [K_W-1:0] K_END   = K_W'(NUM_OAM);
    localparam logic [4:0]     CNT_MAX = 5'(MAX_SPRITES);

    state_t         state_q, state_d;

    // Evaluation context latched on start.
    logic [8:0]     row_q, row_d;
    logic           size_q, size_d;
    logic [7:0]     base_q, base_d;

    // Scan progress for the evaluation in flight (targets the back bank).
    logic [K_W-1:0] k_q, k_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           ovf_q, ovf_d;

    // Published view: which bank is front, and its count / overflow.
    logic           front_q, front_d;
    logic [4:0]     pub_cnt_q, pub_cnt_d;
    logic           pub_ovf_q, pub_ovf_d;

    // Registered read port.
    logic           rd_valid_q, rd_valid_d;
    logic [7:0]     rd_y_q, rd_y_d;
    logic [7:0]     rd_tile_q, rd_tile_d;
    logic [7:0]     rd_attr_q, rd_attr_d;
    logic [7:0]     rd_x_q, rd_x_d;
    logic           rd_is0_q, rd_is0_d;

    // Secondary OAM, two banks. Slot validity is implied by the bank's
    // count (slots fill in order), so the data itself needs no reset.
    logic [7:0]     sec_y_q    [2][MAX_SPRITES];
    logic [7:0]     sec_tile_q [2][MAX_SPRITES];
    logic [7:0]     sec_attr_q [2][MAX_SPRITES];
    logic [7:0]     sec_x_q    [2][MAX_SPRITES];
    logic           sec_is0_q  [2][MAX_SPRITES];

    // Slot field write strobes into the back bank at slot cnt_q.
    logic           wr_y, wr_tile, wr_attr, wr_x;

    logic [7:0]     spram_addr_c;
    logic [7:0]     entry_addr;
    logic [8:0]     y_ext;
    logic [8:0]     row_diff;
    logic [8:0]     height;
    logic           is_hit;
    logic           is_full;
    logic [K_W-1:0] k_inc;
    logic           k_end;
    logic           swap;
    logic           back_bank;

    // Byte address of entry k's Y; the 8-bit add wraps unaligned bases mod 256.
    assign entry_addr = base_q + {k_q[5:0], 2'b00};

    // Row coverage test done in 9 bits so rows past 255 compare correctly.
    assign y_ext    = {1'b0, bus.spram_data_in};
    assign row_diff = row_q - y_ext;
    assign height   = size_q ? 9'd16 : 9'd8;
    assign is_hit   = (row_q >= y_ext) && (row_diff < height) && (bus.spram_data_in < 8'hEF);
    assign is_full  = (cnt_q == CNT_MAX);
    assign k_inc    = k_q + K_W'(1);
    assign k_end    = (k_inc == K_END);

    assign back_bank = ~front_q;

    // The swap lands on the edge entering DONE, so sprite_count and the bank
    // select already show the new line during the done cycle.
    assign swap = (state_d == S_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: 2 cycles per miss, 5 per stored hit, stop on overflow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_ADDR;
            S_ADDR:  state_d = S_CHECK;
            S_CHECK: begin
                if (!is_hit) begin
                    state_d = k_end ? S_DONE : S_ADDR;
                end else if (is_full) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LD_T;
                end
            end
            S_LD_T:  state_d = S_LD_A;
            S_LD_A:  state_d = S_LD_X;
            S_LD_X:  state_d = k_end ? S_DONE : S_ADDR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state outputs: sprite RAM address, slot write strobes, scan counters.
    always_comb begin
        row_d        = row_q;
        size_d       = size_q;
        base_d       = base_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        spram_addr_c = 8'h00;
        wr_y         = 1'b0;
        wr_tile      = 1'b0;
        wr_attr      = 1'b0;
        wr_x         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    row_d  = bus.curr_row;
                    size_d = bus.sprite_size;
                    base_d = bus.cpu_sprite_addr;
                    k_d    = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                end
            end
            S_ADDR: spram_addr_c = entry_addr;
            S_CHECK: begin
                if (!is_hit) begin
                    k_d = k_inc;
                end else if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_y         = 1'b1;
                    spram_addr_c = entry_addr + 8'd1;
                end
            end
            S_LD_T: begin
                wr_tile      = 1'b1;
                spram_addr_c = entry_addr + 8'd2;
            end
            S_LD_A: begin
                wr_attr      = 1'b1;
                spram_addr_c = entry_addr + 8'd3;
            end
            S_LD_X: begin
                wr_x  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                k_d   = k_inc;
            end
            default: ;
        endcase
    end

    // Bank swap and publication of count / overflow for the finished line.
    always_comb begin
        front_d   = front_q;
        pub_cnt_d = pub_cnt_q;
        pub_ovf_d = pub_ovf_q;
        if (swap) begin
            front_d   = ~front_q;
            pub_cnt_d = cnt_d;
            pub_ovf_d = ovf_d;
        end
    end

    // Read-port mux over the front bank; slots at or past the count read as zero.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_y_d     = 8'h00;
        rd_tile_d  = 8'h00;
        rd_attr_d  = 8'h00;
        rd_x_d     = 8'h00;
        rd_is0_d   = 1'b0;
        for (int i = 0; i < MAX_SPRITES; i++) begin
            if ((bus.rd_slot == SLOT_W'(i)) && (5'(i) < pub_cnt_q)) begin
                rd_valid_d = 1'b1;
                rd_y_d     = sec_y_q[front_q][i];
                rd_tile_d  = sec_tile_q[front_q][i];
                rd_attr_d  = sec_attr_q[front_q][i];
                rd_x_d     = sec_x_q[front_q][i];
                rd_is0_d   = sec_is0_q[front_q][i];
            end
        end
    end

    // Context, scan progress, publication and read-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q      <= '0;
            size_q     <= 1'b0;
            base_q     <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            front_q    <= 1'b0;
            pub_cnt_q  <= '0;
            pub_ovf_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_y_q     <= '0;
            rd_tile_q  <= '0;
            rd_attr_q  <= '0;
            rd_x_q     <= '0;
            rd_is0_q   <= 1'b0;
        end else begin
            row_q      <= row_d;
            size_q     <= size_d;
            base_q     <= base_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            front_q    <= front_d;
            pub_cnt_q  <= pub_cnt_d;
            pub_ovf_q  <= pub_ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_y_q     <= rd_y_d;
            rd_tile_q  <= rd_tile_d;
            rd_attr_q  <= rd_attr_d;
            rd_x_q     <= rd_x_d;
            rd_is0_q   <= rd_is0_d;
        end
    end

    // Secondary OAM writes: one field per cycle into back-bank slot cnt_q.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                if ((1'(b) == back_bank) && (cnt_q == 5'(i))) begin
                    if (wr_y) begin
                        sec_y_q[b][i]   <= bus.spram_data_in;
                        sec_is0_q[b][i] <= (k_q == '0);
                    end
                    if (wr_tile) sec_tile_q[b][i] <= bus.spram_data_in;
                    if (wr_attr) sec_attr_q[b][i] <= bus.spram_data_in;
                    if (wr_x)    sec_x_q[b][i]    <= bus.spram_data_in;
                end
            end
        end
    end

    assign bus.spram_addr      = spram_addr_c;
    assign bus.busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done            = (state_q == S_DONE);
    assign bus.sprite_overflow = pub_ovf_q;
    assign bus.sprite_count    = pub_cnt_q;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.rd_y            = rd_y_q;
    assign bus.rd_tile         = rd_tile_q;
    assign bus.rd_attr         = rd_attr_q;
    assign bus.rd_x            = rd_x_q;
    assign bus.rd_is_0         = rd_is0_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_ppu_sprite_eval_engine.sv
// Bench for ppu_sprite_eval_engine: directed table of scanline scenarios,
// randomized OAM contents against a behavioural scan model, and hand-written
// sequences for bank hold-over and mid-scan reset.
module tb_ppu_sprite_eval_engine;

    localparam int MAX_SPRITES = 8;
    localparam int NUM_OAM     = 64;
    localparam int SLOT_W      = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ppu_sprite_eval_engine_if #(.SLOT_W(SLOT_W)) bus();

    ppu_sprite_eval_engine #(
        .MAX_SPRITES(MAX_SPRITES),
        .NUM_OAM    (NUM_OAM),
        .SLOT_W     (SLOT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Primary OAM model with one cycle of read latency.
    logic [7:0] oam [256];
    always @(posedge clk) bus.spram_data_in <= oam[bus.spram_addr];

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];      // {is0, y, tile, attr, x} per expected slot
    logic [7:0]  addr_log[$];   // spram_addr seen on each busy cycle

    typedef struct {
        int         scen;
        logic [7:0] base;
        logic [8:0] row;
        logic       size;
        int         exp_cnt;
        bit         exp_ovf;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    int          m_cnt, m_lat, lat, ybyte;
    bit          m_ovf, flag;
    logic [33:0] old_rd, new_rd;
    logic [7:0]  r_base;
    logic [8:0]  r_row;
    logic        r_size;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [33:0] get_rd();
        return {bus.rd_valid, bus.rd_is_0, bus.rd_y, bus.rd_tile, bus.rd_attr, bus.rd_x};
    endfunction

    function automatic logic [33:0] exp_rd(input int slot);
        if (slot < exp_q.size()) return {1'b1, exp_q[slot]};
        return '0;
    endfunction

    function automatic logic [63:0] all_out();
        return 64'({bus.done, bus.busy, bus.sprite_overflow, bus.sprite_count, bus.spram_addr,
                    bus.rd_valid, bus.rd_is_0, bus.rd_y, bus.rd_tile, bus.rd_attr, bus.rd_x});
    endfunction

    // ---------------- reference model ----------------
    // Walks the entries in OAM order applying the coverage rule directly.
    task automatic model_eval(input logic [7:0] base, input logic [8:0] row, input logic size,
                              output int cnt, output bit ovf, output int lat_o);
        int h, r, a, y, examined;
        h = size ? 16 : 8;
        r = int'(row);
        ovf = 0;
        examined = 0;
        exp_q.delete();
        for (int k = 0; k < NUM_OAM; k++) begin
            a = (int'(base) + 4 * k) % 256;
            y = int'(oam[a]);
            examined++;
            if (r >= y && r - y < h && y < 'hEF) begin
                if (exp_q.size() == MAX_SPRITES) begin
                    ovf = 1;
                    break;
                end
                exp_q.push_back({(k == 0) ? 1'b1 : 1'b0, oam[a], oam[(a + 1) % 256],
                                 oam[(a + 2) % 256], oam[(a + 3) % 256]});
            end
        end
        cnt   = exp_q.size();
        lat_o = 2 * examined + 3 * cnt + 1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    endtask

    task automatic put_entry(input logic [7:0] base, input int k, input logic [7:0] y,
                             input logic [7:0] t, input logic [7:0] a, input logic [7:0] x);
        logic [7:0] p;
        p = base + 8'(4 * k);
        oam[p] = y;
        p = p + 8'd1; oam[p] = t;
        p = p + 8'd1; oam[p] = a;
        p = p + 8'd1; oam[p] = x;
    endtask

    task automatic load_scen(input int id);
        clear_oam();
        case (id)
            0: for (int k = 0; k < 10; k++)
                   if (k == 0 || k == 5 || k == 9)
                       put_entry(8'h00, k, 8'h10, 8'(8'h40 + k), 8'(8'hC0 ^ k), 8'(8'h08 + 3 * k));
            1: for (int k = 0; k < 10; k++)
                   put_entry(8'h00, k, 8'h20, 8'(8'h50 + k), 8'(k), 8'(8'hA0 + k));
            2: put_entry(8'h00, 0, 8'h30, 8'h31, 8'h32, 8'h33);
            3: put_entry(8'h00, 0, 8'hEF, 8'h01, 8'h02, 8'h03);
            4: begin
                put_entry(8'hFE, 0, 8'h50, 8'h11, 8'h22, 8'h33);
                put_entry(8'hFE, 1, 8'h50, 8'h44, 8'h55, 8'h66);
            end
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    // Pulses start and waits for done; lat counts cycles from the first busy
    // cycle to the done cycle, -1 if done never arrived.
    task automatic run_eval(input logic [7:0] base, input logic [8:0] row, input logic size,
                            output int lat_o, output bit busy_ok);
        @(negedge clk);
        bus.cpu_sprite_addr = base;
        bus.curr_row        = row;
        bus.sprite_size     = size;
        bus.start           = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat_o   = 1;
        busy_ok = 1;
        addr_log.delete();
        while (bus.done !== 1'b1 && lat_o < 400) begin
            addr_log.push_back(bus.spram_addr);
            if (bus.busy !== 1'b1) busy_ok = 0;
            @(negedge clk);
            lat_o++;
        end
        if (bus.done !== 1'b1) lat_o = -1;
        else if (bus.busy !== 1'b0) busy_ok = 0;
    endtask

    task automatic check_slots(input string tag);
        int slot;
        for (int s = 0; s <= MAX_SPRITES + 1; s++) begin
            slot = (s == MAX_SPRITES + 1) ? 15 : s;
            bus.rd_slot = SLOT_W'(slot);
            @(negedge clk);
            check($sformatf("%s_slot%0d", tag, slot), 64'(get_rd()), 64'(exp_rd(slot)));
        end
    endtask

    task automatic eval_and_check(input string tag, input logic [7:0] base, input logic [8:0] row,
                                  input logic size, input int want_cnt, input bit want_ovf,
                                  input int want_lat);
        int l;
        bit busy_ok;
        run_eval(base, row, size, l, busy_ok);
        check({tag, "_count"}, 64'(bus.sprite_count), 64'(want_cnt));
        check({tag, "_ovf"}, 64'(bus.sprite_overflow), 64'(want_ovf));
        check({tag, "_lat"}, 64'(l), 64'(want_lat));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check_slots(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        rst                 = 1'b1;
        bus.start           = 1'b0;
        bus.curr_row        = '0;
        bus.sprite_size     = 1'b0;
        bus.cpu_sprite_addr = '0;
        bus.rd_slot         = '0;
        clear_oam();
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios with hand-derived count / overflow / latency.
        vecs[0] = '{0, 8'h00, 9'h014, 1'b0, 3, 1'b0, 138};
        vecs[1] = '{1, 8'h00, 9'h022, 1'b0, 8, 1'b1, 43};
        vecs[2] = '{2, 8'h00, 9'h03A, 1'b0, 0, 1'b0, 129};
        vecs[3] = '{2, 8'h00, 9'h03A, 1'b1, 1, 1'b0, 132};
        vecs[4] = '{3, 8'h00, 9'h0F0, 1'b1, 0, 1'b0, 129};
        vecs[5] = '{4, 8'hFE, 9'h052, 1'b0, 2, 1'b0, 135};
        for (int v = 0; v < 6; v++) begin
            load_scen(vecs[v].scen);
            model_eval(vecs[v].base, vecs[v].row, vecs[v].size, m_cnt, m_ovf, m_lat);
            eval_and_check($sformatf("vec%0d", v), vecs[v].base, vecs[v].row, vecs[v].size,
                           vecs[v].exp_cnt, vecs[v].exp_ovf, vecs[v].exp_lat);
            if (vecs[v].scen == 4) begin
                check("wrap_addr_e0", 64'((addr_log.size() > 0) ? addr_log[0] : 8'h00), 64'h0FE);
                check("wrap_addr_e1", 64'((addr_log.size() > 5) ? addr_log[5] : 8'h00), 64'h002);
            end
        end

        // Randomized OAM contents checked against the model.
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < 256; i++) oam[i] = 8'($urandom);
            r_base = 8'($urandom_range(0, 255));
            r_row  = 9'($urandom_range(0, 300));
            r_size = 1'($urandom_range(0, 1));
            for (int k = 0; k < NUM_OAM; k++) begin
                if ($urandom_range(0, (it % 2 == 0) ? 1 : 5) == 0) begin
                    ybyte = int'(r_row) - int'($urandom_range(0, 17));
                    if (ybyte >= 0 && ybyte <= 255) oam[8'(int'(r_base) + 4 * k)] = 8'(ybyte);
                end
            end
            model_eval(r_base, r_row, r_size, m_cnt, m_ovf, m_lat);
            eval_and_check($sformatf("rnd%0d", it), r_base, r_row, r_size, m_cnt, m_ovf, m_lat);
        end

        // Front bank holds during the next evaluation; start while busy is dropped.
        load_scen(0);
        model_eval(8'h00, 9'h014, 1'b0, m_cnt, m_ovf, m_lat);
        eval_and_check("hold_first", 8'h00, 9'h014, 1'b0, m_cnt, m_ovf, m_lat);
        old_rd = exp_rd(0);
        bus.rd_slot = '0;
        @(negedge clk);
        check("hold_pre", 64'(get_rd()), 64'(old_rd));
        clear_oam();
        put_entry(8'h00, 3, 8'h60, 8'h71, 8'h72, 8'h73);
        model_eval(8'h00, 9'h061, 1'b0, m_cnt, m_ovf, m_lat);
        new_rd = exp_rd(0);
        bus.cpu_sprite_addr = 8'h00;
        bus.curr_row        = 9'h061;
        bus.sprite_size     = 1'b0;
        bus.start           = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 400) begin
            check($sformatf("hold_c%0d", lat), 64'(get_rd()), 64'(old_rd));
            bus.start = (lat == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("hold_lat", 64'(lat), 64'(m_lat));
        check("hold_at_done", 64'(get_rd()), 64'(old_rd));
        @(negedge clk);
        check("hold_after", 64'(get_rd()), 64'(new_rd));
        check("hold_count", 64'(bus.sprite_count), 64'(m_cnt));
        flag = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) flag = 1;
        end
        check("busy_start_ignored", 64'(flag), 64'd0);

        // Reset during LD_A aborts the scan with no done pulse.
        load_scen(0);
        model_eval(8'h00, 9'h014, 1'b0, m_cnt, m_ovf, m_lat);
        eval_and_check("rst_first", 8'h00, 9'h014, 1'b0, m_cnt, m_ovf, m_lat);
        bus.rd_slot = '0;
        @(negedge clk);
        check("rst_pre_valid", 64'(bus.rd_valid), 64'd1);
        bus.start = 1'b1;
        @(negedge clk);               // ADDR
        bus.start = 1'b0;
        flag = 0;
        repeat (3) begin              // CHECK, LD_T, LD_A
            @(negedge clk);
            if (bus.done !== 1'b0) flag = 1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", all_out(), 64'd0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) flag = 1;
        end
        check("rst_no_done", 64'(flag), 64'd0);
        check("rst_count_cleared", 64'(bus.sprite_count), 64'd0);
        eval_and_check("rst_after", 8'h00, 9'h014, 1'b0, m_cnt, m_ovf, m_lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppu_sprite_eval_engine.md
Name: ppu_sprite_eval_engine

Overview:
- Parametrised per-scanline sprite evaluator for the PPU. It scans primary OAM (sprite RAM) for sprites that cover the requested row, in either 8- or 16-line sprite mode.
- Collects up to MAX_SPRITES hits into a double-buffered secondary OAM. The renderer reads the published bank through a registered slot-indexed port while the next line is evaluated into the other bank.
- Sits between sprite RAM and the sprite pixel pipeline. Adds a configurable hit limit, 8x16 mode, bank swapping, a completion pulse and a published hit count.

Parameters:
- MAX_SPRITES, 8, secondary OAM slots per line; legal range 1..16.
- NUM_OAM, 64, primary OAM entries scanned per evaluation; legal range 1..64.
- SLOT_W, 4, width of the slot index; must satisfy 2^SLOT_W >= MAX_SPRITES.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- start, in, 1, single-cycle pulse that begins an evaluation; ignored while busy.
- curr_row, in, 9, scanline being evaluated; sampled on start.
- sprite_size, in, 1, 0 = 8-line sprites, 1 = 16-line sprites; sampled on start.
- cpu_sprite_addr, in, 8, OAM base byte address; sampled on start.
- spram_addr, out, 8, sprite RAM byte address.
- spram_data_in, in, 8, sprite RAM data; valid exactly 1 cycle after the address.
- busy, out, 1, high from the cycle after start until done.
- done, out, 1, 1-cycle pulse; same cycle as the bank swap.
- sprite_overflow, out, 1, published overflow flag for the last completed evaluation.
- sprite_count, out, 5, published number of valid slots (0..MAX_SPRITES).
- rd_slot, in, SLOT_W, slot to read from the published bank.
- rd_valid, out, 1, the read slot holds a sprite.
- rd_y, out, 8, Y byte of the read slot.
- rd_tile, out, 8, tile byte of the read slot.
- rd_attr, out, 8, attribute byte of the read slot.
- rd_x, out, 8, X byte of the read slot.
- rd_is_0, out, 1, the read slot holds OAM entry 0 of the scan (the entry at cpu_sprite_addr).

Behaviour:
- Reset values:
  - All outputs 0, spram_addr 0.
  - Both banks invalid; front bank index 0; state IDLE.
  - A reset mid-scan aborts the scan. No done pulse is produced and no bank swap occurs.
- Height H is 8 or 16. Entry k is a hit when all of the following hold, computed in 9 bits:
  - curr_row >= Y;
  - curr_row - Y < H;
  - Y < 0xEF.
- Entry k's bytes are at cpu_sprite_addr + 4k + {0,1,2,3}, computed mod 256. Unaligned bases wrap and do not saturate.
- States:
  - IDLE: on start, latch the inputs, clear the back bank (all slots invalid, count 0, overflow 0), set k = 0, go to ADDR.
  - ADDR: drive the Y address of entry k; go to CHECK.
  - CHECK: spram_data_in holds Y.
    - Miss: k++. Go to DONE if k == NUM_OAM, else go to ADDR. A miss costs 2 cycles.
    - Hit with count < MAX_SPRITES: store Y and is_0 = (k == 0), drive address +1, go to LD_T.
    - Hit with count == MAX_SPRITES: set overflow, go to DONE. The scan stops; later entries are not examined.
  - LD_T: capture tile, drive +2. Then LD_A: capture attr, drive +3. Then LD_X: capture X, mark the slot valid, count++, k++, then DONE if k == NUM_OAM else ADDR. A hit costs 5 cycles.
  - DONE: swap banks, publish count and overflow, pulse done, return to IDLE. busy is low in the same cycle.
- Slots fill in ascending OAM order; slot 0 is the lowest k hit.
- Read port:
  - Registered, 1-cycle latency from rd_slot to the outputs.
  - Reads the front bank only and is unaffected by the scan in progress.
  - When rd_slot >= sprite_count (including rd_slot >= MAX_SPRITES): rd_valid = 0 and all data outputs are 0.
  - The read outputs reflect the new bank from the cycle after done.
- Worst-case latency, start to done: 1 + 2*NUM_OAM + 3*min(hits, MAX_SPRITES) + 1 cycles.

Test Plan:
- Y = 0x10 at entries 0, 5, 9, default params, curr_row = 0x14, base 0 -> done pulses, sprite_count = 3, slot0 rd_is_0 = 1, slot2 data = entry 9 bytes, rd_valid(3) = 0.
- 10 entries with Y = 0x20, curr_row = 0x22, MAX_SPRITES = 8 -> sprite_count = 8, sprite_overflow = 1, scan ends on the 9th hit check (entry 9 not examined, done earlier than a full scan).
- Entry Y = 0x30, curr_row = 0x3A: sprite_size = 0 -> count 0; sprite_size = 1 -> count 1. Y = 0xEF with curr_row = 0xF0 -> no hit.
- cpu_sprite_addr = 0xFE -> the entry 0 Y address is 0xFE and the entry 1 Y address is 0x02 (wrap); data is loaded from the wrapped addresses.
- Hold rd_slot = 0 during a second evaluation -> read data is unchanged until the cycle after done, then shows the new line. A start while busy is ignored.
- Assert rst during LD_A -> no done pulse; all outputs 0 on the next cycle; the next start performs a clean evaluation.
